// File: rtl/neuron_mac_if.sv
// Stream interface of the neuron: x/w/b input beats in, saturated y out.
interface neuron_mac_if #(
  parameter int unsigned DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] w;
  logic signed [DATA_W-1:0] b;
  logic [1:0]               act_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] y;
  logic                     out_sat;

  // Producer of input beats / consumer of results
  modport master (
    output in_valid, x, w, b, act_mode, out_ready,
    input  in_ready, out_valid, y, out_sat
  );

  // The neuron itself
  modport slave (
    input  in_valid, x, w, b, act_mode, out_ready,
    output in_ready, out_valid, y, out_sat
  );
endinterface

// File: rtl/neuron_mac.sv
// Fixed-point neuron: pipelined MAC over N_INPUTS beats, bias, activation, saturation.
module neuron_mac #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned N_INPUTS = 5,
  parameter int unsigned ACC_W    = 40
) (
  input  logic         clk,
  input  logic         rst,
  neuron_mac_if.slave  bus
);

  localparam int unsigned CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(64'sd1 <<< (DATA_W - 1)));
  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {S_ACC, S_FLUSH, S_OUT} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     flush_cnt;
  logic signed [DATA_W-1:0] b_q;
  logic [1:0]               mode_q;
  logic signed [PROD_W-1:0] prod;
  logic                     p_valid;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] y_q;
  logic                     out_sat_q;

  logic                     accept_c;
  logic                     last_beat_c;
  logic                     flush_done_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  shift_c;
  logic signed [ACC_W-1:0]  act_c;
  logic signed [DATA_W-1:0] clip_c;
  logic                     sat_c;

  assign accept_c     = bus.in_valid && bus.in_ready;
  assign last_beat_c  = (beat_cnt == CNT_W'(N_INPUTS - 1));
  assign flush_done_c = flush_cnt;
  assign bus.y        = y_q;
  assign bus.out_sat  = out_sat_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= state_nxt;
  end

  // Next-state: collect beats, drain the two pipeline stages, hold the result
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (accept_c && last_beat_c) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_done_c)            state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready)           state_nxt = S_ACC;
      default:                              state_nxt = S_ACC;
    endcase
  end

  // Handshake outputs decoded from the state register; in_ready held low during reset
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      S_ACC:   bus.in_ready  = !rst;
      S_OUT:   bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Result formation: bias, rescale (floor), activation, clip to DATA_W
  always_comb begin
    sum_c   = acc + (ACC_W'(b_q) <<< FRAC_W);
    shift_c = sum_c >>> FRAC_W;
    act_c   = shift_c;
    case (mode_q)
      2'd1:    if (shift_c[ACC_W-1]) act_c = '0;
      2'd2:    if (shift_c[ACC_W-1]) act_c = shift_c >>> 3;
      default: act_c = shift_c;
    endcase
    sat_c  = 1'b0;
    clip_c = DATA_W'(act_c);
    if (act_c > Y_MAX) begin
      clip_c = D_MAX;
      sat_c  = 1'b1;
    end else if (act_c < Y_MIN) begin
      clip_c = D_MIN;
      sat_c  = 1'b1;
    end
  end

  // Datapath: beat counter, multiply stage, accumulate stage, result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      flush_cnt <= 1'b0;
      b_q       <= '0;
      mode_q    <= '0;
      prod      <= '0;
      p_valid   <= 1'b0;
      acc       <= '0;
      y_q       <= '0;
      out_sat_q <= 1'b0;
    end else begin
      p_valid <= accept_c;
      if (accept_c) begin
        prod     <= PROD_W'(bus.x) * PROD_W'(bus.w);
        beat_cnt <= last_beat_c ? '0 : beat_cnt + CNT_W'(1);
      end
      if (accept_c && (beat_cnt == '0)) begin
        b_q    <= bus.b;
        mode_q <= bus.act_mode;
        acc    <= '0;
      end else if (p_valid) begin
        acc <= acc + ACC_W'(prod);
      end
      flush_cnt <= (state == S_FLUSH) ? ~flush_cnt : 1'b0;
      if ((state == S_FLUSH) && flush_done_c) begin
        y_q       <= clip_c;
        out_sat_q <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac.
module tb_neuron_mac;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_mac_if #(.DATA_W(16)) bus();

  neuron_mac #(
    .DATA_W(16), .FRAC_W(8), .N_INPUTS(5), .ACC_W(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] vx [5];
  logic [15:0] vw [5];

  // Drive the five beats of vx/vw; later beats carry junk b/act_mode that must be ignored
  task automatic send_vec(input logic [15:0] bias, input logic [1:0] mode, input bit bubbles);
    int i;
    int guard;
    bit took;
    i = 0;
    guard = 0;
    while (i < 5 && guard < 200) begin
      guard++;
      bus.in_valid = 1'b1;
      bus.x        = vx[i];
      bus.w        = vw[i];
      bus.b        = (i == 0) ? bias : 16'h7F00;
      bus.act_mode = (i == 0) ? mode : ~mode;
      took         = bus.in_ready;
      @(negedge clk);
      if (took) i++;
      if (bubbles) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (i != 5) begin
      bad++;
      $display("FAIL send_vec beats accepted=%0d required=5", i);
    end
  endtask

  // Wait for out_valid; lat counts cycles from the last accepted beat's cycle
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (!bus.out_valid) begin
      bad++;
      $display("FAIL wait_out out_valid=0 required=1 after %0d cycles", lat);
    end
  endtask

  // One full evaluation: send, wait, capture result, complete the output handshake
  task automatic run_vec(input logic [15:0] bias, input logic [1:0] mode, input bit bubbles,
                         output logic [15:0] yo, output logic so, output int lat);
    send_vec(bias, mode, bubbles);
    wait_out(lat);
    yo = bus.y;
    so = bus.out_sat;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic load_basic(input logic [15:0] wv);
    vx = '{16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0300};
    for (int i = 0; i < 5; i++) vw[i] = wv;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x = '0; bus.w = '0; bus.b = '0; bus.act_mode = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.y !== 16'h0000) begin bad++; $display("FAIL reset_y got=%h exp=0000", bus.y); end
    total++; if (bus.out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b exp=0", bus.out_sat); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] yo; logic so; int lat;
    load_basic(16'h0100);
    run_vec(16'h0080, 2'd0, 1'b0, yo, so, lat);
    total++; if (yo !== 16'h0600) begin bad++; $display("FAIL basic_y got=%h exp=0600", yo); end
    total++; if (so !== 1'b0) begin bad++; $display("FAIL basic_sat got=%b exp=0", so); end
    total++; if (lat != 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_modes;
    logic [15:0] yo; logic so; int lat;
    logic [15:0] ey [3];
    ey = '{16'hFB00, 16'h0000, 16'hFF60};
    load_basic(16'hFF00);
    for (int m = 0; m < 3; m++) begin
      run_vec(16'h0080, 2'(m), 1'b0, yo, so, lat);
      total++; if (yo !== ey[m]) begin bad++; $display("FAIL mode%0d_y got=%h exp=%h", m, yo, ey[m]); end
      total++; if (so !== 1'b0) begin bad++; $display("FAIL mode%0d_sat got=%b exp=0", m, so); end
    end
  endtask

  task automatic test_saturation;
    logic [15:0] yo; logic so; int lat;
    for (int i = 0; i < 5; i++) begin vx[i] = 16'h7FFF; vw[i] = 16'h7FFF; end
    run_vec(16'h0000, 2'd0, 1'b0, yo, so, lat);
    total++; if (yo !== 16'h7FFF) begin bad++; $display("FAIL sat_pos_y got=%h exp=7FFF", yo); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL sat_pos_flag got=%b exp=1", so); end
    for (int i = 0; i < 5; i++) vw[i] = 16'h8000;
    run_vec(16'h0000, 2'd0, 1'b0, yo, so, lat);
    total++; if (yo !== 16'h8000) begin bad++; $display("FAIL sat_neg_y got=%h exp=8000", yo); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL sat_neg_flag got=%b exp=1", so); end
  endtask

  task automatic test_backpressure;
    int lat;
    load_basic(16'h0100);
    send_vec(16'h0080, 2'd0, 1'b0);
    wait_out(lat);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1; bus.x = 16'h7FFF; bus.w = 16'h7FFF; bus.b = 16'h7FFF; bus.act_mode = 2'd0;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid c=%0d got=%b exp=1", c, bus.out_valid); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, bus.in_ready); end
      total++; if (bus.y !== 16'h0600) begin bad++; $display("FAIL bp_y c=%0d got=%h exp=0600", c, bus.y); end
      total++; if (bus.out_sat !== 1'b0) begin bad++; $display("FAIL bp_sat c=%0d got=%b exp=0", c, bus.out_sat); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_bubbles;
    logic [15:0] yo; logic so; int lat;
    load_basic(16'h0100);
    run_vec(16'h0080, 2'd0, 1'b1, yo, so, lat);
    total++; if (yo !== 16'h0600) begin bad++; $display("FAIL bubbles_y got=%h exp=0600", yo); end
    total++; if (so !== 1'b0) begin bad++; $display("FAIL bubbles_sat got=%b exp=0", so); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] yo; logic so; int lat;
    load_basic(16'h0100);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.x = 16'h7FFF; bus.w = 16'h7FFF; bus.b = 16'h7FFF; bus.act_mode = 2'd0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid c=%0d got=%b exp=0", c, bus.out_valid); end
    end
    run_vec(16'h0080, 2'd0, 1'b0, yo, so, lat);
    total++; if (yo !== 16'h0600) begin bad++; $display("FAIL mid_rst_y got=%h exp=0600", yo); end
    total++; if (lat != 3) begin bad++; $display("FAIL mid_rst_latency got=%0d exp=3", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_saturation();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
